// File: rtl/aes_wb_slave_pkg.sv
// Shared definitions for the AES Wishbone slave: register word indices, CTRL/STATUS bit
// positions, FSM state encoding and a byte-lane merge helper.
package aes_wb_slave_pkg;

  // Word index = byte offset >> 2.
  localparam logic [3:0] AesCtrl   = 4'h0;
  localparam logic [3:0] AesStatus = 4'h1;
  localparam logic [3:0] AesDin0   = 4'h2;
  localparam logic [3:0] AesDin1   = 4'h3;
  localparam logic [3:0] AesDin2   = 4'h4;
  localparam logic [3:0] AesDin3   = 4'h5;
  localparam logic [3:0] AesDout0  = 4'h6;
  localparam logic [3:0] AesDout1  = 4'h7;
  localparam logic [3:0] AesDout2  = 4'h8;
  localparam logic [3:0] AesDout3  = 4'h9;

  localparam int unsigned CtrlStartBit    = 0;
  localparam int unsigned CtrlIrqEnBit    = 1;
  localparam int unsigned StatReadyBit    = 0;
  localparam int unsigned StatDoneBit     = 1;
  localparam int unsigned StatOverrunBit  = 2;
  localparam int unsigned StatBusyBit     = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssued  = 2'd1,
    StRunning = 2'd2
  } aes_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = sel[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_wb_slave.sv
// Wishbone B4 classic register bank driving the AES wrapper start/ready handshake, with
// plaintext/result registers, sticky DONE/OVERRUN status and a level interrupt.
module aes_wb_slave
  import aes_wb_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              aes_start,
  output logic [31:0]       aes_in0,
  output logic [31:0]       aes_in1,
  output logic [31:0]       aes_in2,
  output logic [31:0]       aes_in3,
  input  logic [31:0]       aes_out0,
  input  logic [31:0]       aes_out1,
  input  logic [31:0]       aes_out2,
  input  logic [31:0]       aes_out3,
  input  logic              aes_ready,
  output logic              irq
);

  aes_state_e  state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        start_q, start_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic        irq_q, irq_d;
  logic [31:0] din_q  [4];
  logic [31:0] din_d  [4];
  logic [31:0] dout_q [4];
  logic [31:0] dout_d [4];

  logic        acc, wr, rd, start_req, hw_done, hw_ovr;
  logic [3:0]  idx, din_off;
  logic [31:0] status_word;
  logic        unused_adr;

  assign unused_adr = ^wb_adr_i;
  assign idx        = wb_adr_i[5:2];
  assign din_off    = idx - AesDin0;

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    dat_d    = 32'h0;
    start_d  = 1'b0;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    din_d    = din_q;
    dout_d   = dout_q;
    hw_done  = 1'b0;
    hw_ovr   = 1'b0;

    acc       = wb_cyc_i & wb_stb_i & ~ack_q;
    wr        = acc & wb_we_i;
    rd        = acc & ~wb_we_i;
    ack_d     = acc;
    start_req = wr && (idx == AesCtrl) && wb_sel_i[0] && wb_dat_i[CtrlStartBit];

    status_word                 = 32'h0;
    status_word[StatReadyBit]   = aes_ready;
    status_word[StatDoneBit]    = done_q;
    status_word[StatOverrunBit] = ovr_q;
    status_word[StatBusyBit]    = (state_q != StIdle);

    if (wr) begin
      case (idx)
        AesCtrl: begin
          if (wb_sel_i[0]) irq_en_d = wb_dat_i[CtrlIrqEnBit];
        end
        AesStatus: begin
          if (wb_sel_i[0] && wb_dat_i[StatDoneBit])    done_d = 1'b0;
          if (wb_sel_i[0] && wb_dat_i[StatOverrunBit]) ovr_d  = 1'b0;
        end
        AesDin0, AesDin1, AesDin2, AesDin3: begin
          // Plaintext is frozen while the wrapper may still be sampling it.
          if (state_q == StIdle) begin
            din_d[din_off[1:0]] = merge_bytes(din_q[din_off[1:0]], wb_dat_i, wb_sel_i);
          end else begin
            hw_ovr = 1'b1;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (start_req) begin
          start_d = 1'b1;
          state_d = StIssued;
        end
      end
      StIssued: begin
        if (!aes_ready) state_d = StRunning;
      end
      StRunning: begin
        if (aes_ready) begin
          dout_d[0] = aes_out0;
          dout_d[1] = aes_out1;
          dout_d[2] = aes_out2;
          dout_d[3] = aes_out3;
          hw_done   = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_req && (state_q != StIdle)) hw_ovr = 1'b1;

    // Hardware set overrides a same-cycle W1C.
    if (hw_done) done_d = 1'b1;
    if (hw_ovr)  ovr_d  = 1'b1;

    irq_d = done_q & irq_en_q;

    if (rd) begin
      case (idx)
        AesCtrl:   dat_d = {30'h0, irq_en_q, 1'b0};
        AesStatus: dat_d = status_word;
        AesDin0:   dat_d = din_q[0];
        AesDin1:   dat_d = din_q[1];
        AesDin2:   dat_d = din_q[2];
        AesDin3:   dat_d = din_q[3];
        AesDout0:  dat_d = dout_q[0];
        AesDout1:  dat_d = dout_q[1];
        AesDout2:  dat_d = dout_q[2];
        AesDout3:  dat_d = dout_q[3];
        default:   dat_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      ack_q    <= 1'b0;
      dat_q    <= 32'h0;
      start_q  <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        din_q[i]  <= 32'h0;
        dout_q[i] <= 32'h0;
      end
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      start_q  <= start_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      irq_q    <= irq_d;
      for (int i = 0; i < 4; i++) begin
        din_q[i]  <= din_d[i];
        dout_q[i] <= dout_d[i];
      end
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign aes_start = start_q;
  assign aes_in0   = din_q[0];
  assign aes_in1   = din_q[1];
  assign aes_in2   = din_q[2];
  assign aes_in3   = din_q[3];
  assign irq       = irq_q;

endmodule

// File: tb/tb_aes_wb_slave.sv
// Directed self-checking bench for aes_wb_slave with a simple AES wrapper model.
module tb_aes_wb_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [5:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, aes_start, irq;
  logic [31:0] aes_in0, aes_in1, aes_in2, aes_in3;
  logic [31:0] aes_out0 = '0, aes_out1 = '0, aes_out2 = '0, aes_out3 = '0;
  logic        aes_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;
  logic [31:0] cap_in [4];

  always #5 clk = ~clk;

  aes_wb_slave #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .aes_start(aes_start),
    .aes_in0(aes_in0), .aes_in1(aes_in1), .aes_in2(aes_in2), .aes_in3(aes_in3),
    .aes_out0(aes_out0), .aes_out1(aes_out1), .aes_out2(aes_out2), .aes_out3(aes_out3),
    .aes_ready(aes_ready), .irq(irq)
  );

  // Wrapper model: on each start-high cycle, latch inputs, go busy for 12 cycles.
  always begin
    @(negedge clk);
    if (aes_start === 1'b1) begin
      n_pulse++;
      cap_in[0] = aes_in0; cap_in[1] = aes_in1; cap_in[2] = aes_in2; cap_in[3] = aes_in3;
      aes_ready = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      aes_ready = 1'b1;
    end
  end

  task automatic wb_xfer(input logic we, input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rdat, output int lat);
    bit got;
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = a;
    wb_dat_i = d; wb_sel_i = s;
    got = 1'b0; lat = 0; rdat = 'x;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (wb_ack_o === 1'b1) begin
        got = 1'b1;
        rdat = wb_dat_o;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL bus_ack_timeout adr=%h: no ack, required ack within 8 cycles", a);
      lat = -1;
    end
  endtask

  task automatic wb_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] unused_rd;
    int lat;
    wb_xfer(1'b1, a, d, s, unused_rd, lat);
  endtask

  task automatic wb_read(input logic [5:0] a, output logic [31:0] d);
    int lat;
    wb_xfer(1'b0, a, 32'h0, 4'hF, d, lat);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] st;
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      wb_read(6'h04, st);
      if (st[1] === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_done_timeout: DONE never set, required DONE=1", tag);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    n_vec++;
    if (wb_ack_o !== 1'b0 || aes_start !== 1'b0 || irq !== 1'b0 || aes_in0 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: ack=%b start=%b irq=%b in0=%h, required all 0",
               wb_ack_o, aes_start, irq, aes_in0);
    end
    wb_read(6'h04, r);
    n_vec++;
    if (r !== 32'h1) begin
      n_err++; $display("FAIL reset_status: got %h, required 00000001", r);
    end
    wb_read(6'h00, r);
    n_vec++;
    if (r !== 32'h0) begin
      n_err++; $display("FAIL reset_ctrl: got %h, required 00000000", r);
    end
  endtask

  task automatic test_encrypt();
    logic [31:0] r;
    logic [31:0] exp_in  [4];
    logic [31:0] exp_out [4];
    exp_in  = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    exp_out = '{32'h69C4E0D8, 32'h6A7B0430, 32'hD8CDB780, 32'h70B4C55A};
    aes_out0 = exp_out[0]; aes_out1 = exp_out[1]; aes_out2 = exp_out[2]; aes_out3 = exp_out[3];
    for (int i = 0; i < 4; i++) wb_write(6'(8 + 4*i), exp_in[i], 4'hF);
    wb_write(6'h00, 32'h3, 4'hF);
    wait_done("encrypt");
    n_vec++;
    if (n_pulse !== 1) begin
      n_err++; $display("FAIL encrypt_pulses: got %0d start cycles, required 1", n_pulse);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (cap_in[i] !== exp_in[i]) begin
        n_err++; $display("FAIL encrypt_aes_in%0d: got %h, required %h", i, cap_in[i], exp_in[i]);
      end
      wb_read(6'(24 + 4*i), r);
      n_vec++;
      if (r !== exp_out[i]) begin
        n_err++; $display("FAIL encrypt_dout%0d: got %h, required %h", i, r, exp_out[i]);
      end
    end
    wb_read(6'h04, r);
    n_vec++;
    if (r !== 32'h3) begin
      n_err++; $display("FAIL encrypt_status: got %h, required 00000003", r);
    end
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL encrypt_irq: got %b, required 1", irq);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] r;
    wb_write(6'h04, 32'h2, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL w1c_irq: got %b, required 0", irq);
    end
    wb_read(6'h04, r);
    n_vec++;
    if (r !== 32'h1) begin
      n_err++; $display("FAIL w1c_status: got %h, required 00000001", r);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] r;
    wb_write(6'h00, 32'h3, 4'hF);
    wb_write(6'h00, 32'h3, 4'hF);
    wb_write(6'h0C, 32'hDEADBEEF, 4'hF);
    n_vec++;
    if (aes_in1 !== 32'h44556677) begin
      n_err++; $display("FAIL overrun_aes_in1: got %h, required 44556677", aes_in1);
    end
    wait_done("overrun");
    n_vec++;
    if (n_pulse !== 2) begin
      n_err++; $display("FAIL overrun_pulses: got %0d total start cycles, required 2", n_pulse);
    end
    wb_read(6'h04, r);
    n_vec++;
    if (r !== 32'h7) begin
      n_err++; $display("FAIL overrun_status: got %h, required 00000007", r);
    end
    wb_read(6'h0C, r);
    n_vec++;
    if (r !== 32'h44556677) begin
      n_err++; $display("FAIL overrun_din1: got %h, required 44556677", r);
    end
    wb_write(6'h04, 32'h6, 4'hF);
    wb_read(6'h04, r);
    n_vec++;
    if (r !== 32'h1) begin
      n_err++; $display("FAIL overrun_clear: got %h, required 00000001", r);
    end
  endtask

  task automatic test_byte_sel();
    logic [31:0] r;
    int lat;
    wb_write(6'h10, 32'hAAAAAAAA, 4'b0100);
    wb_read(6'h10, r);
    n_vec++;
    if (r !== 32'h88AAAABB) begin
      n_err++; $display("FAIL sel_din2: got %h, required 88AAAABB", r);
    end
    wb_xfer(1'b0, 6'h3C, 32'h0, 4'hF, r, lat);
    n_vec++;
    if (r !== 32'h0 || lat !== 1) begin
      n_err++; $display("FAIL unmapped_read: got %h lat %0d, required 00000000 lat 1", r, lat);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r;
    bit seen;
    aes_out0 = 32'h12345678;
    wb_write(6'h00, 32'h1, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (aes_ready === 1'b0) seen = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_vec++;
    if (!seen || aes_in0 !== 32'h0 || irq !== 1'b0 || aes_start !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: busy_seen=%b in0=%h irq=%b start=%b, required 1/0/0/0",
               seen, aes_in0, irq, aes_start);
    end
    wb_read(6'h04, r);
    n_vec++;
    if (r !== {31'h0, aes_ready}) begin
      n_err++; $display("FAIL rst_mid_status: got %h, required %h", r, {31'h0, aes_ready});
    end
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (aes_ready === 1'b1) seen = 1'b1;
    end
    repeat (4) @(posedge clk);
    wb_read(6'h04, r);
    n_vec++;
    if (!seen || r !== 32'h1) begin
      n_err++; $display("FAIL rst_mid_no_done: ready_seen=%b status %h, required 1 / 00000001",
                        seen, r);
    end
    wb_read(6'h18, r);
    n_vec++;
    if (r !== 32'h0) begin
      n_err++; $display("FAIL rst_mid_dout0: got %h, required 00000000", r);
    end
    wb_read(6'h00, r);
    n_vec++;
    if (r !== 32'h0) begin
      n_err++; $display("FAIL rst_mid_ctrl: got %h, required 00000000", r);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_encrypt();
    test_w1c();
    test_overrun();
    test_byte_sel();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
